// File: rtl/digital_filter_readout.sv
// Serial readout of a digital filter: a falling edge on new_data starts a
// WIDTH-bit MSB-first capture through the shift strobe. Completed words go
// into a small first-word-fall-through FIFO. Sticky flags report dropped
// words (overflow) and frame starts that arrive mid-capture (missed).
module digital_filter_readout #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     new_data,
   input  logic                     serial_data_in,
   output logic                     shift,
   output logic                     busy,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     missed,
   input  logic                     clear_flags
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

   state_t             state_q, state_d;
   logic               nd_q;
   logic [WIDTH-1:0]   cap_q, cap_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               missed_q, missed_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               frame_start;
   logic               full;
   logic               pop;
   logic               wr_en;

   // The word leaves the FIFO only with a valid head; a full FIFO still
   // accepts a push if the head is consumed on the same edge.
   assign frame_start = nd_q & ~new_data;
   assign full        = (level_q == LVL_W'(DEPTH));
   assign pop         = (level_q != '0) && dout_ready;
   assign wr_en       = (state_q == PUSH) && (!full || pop);

   assign dout        = mem_q[rd_ptr_q];
   assign dout_valid  = (level_q != '0);
   assign level       = level_q;
   assign overflow    = ovf_q;
   assign missed      = missed_q;

   // Capture FSM: next state, shift strobe, busy and serial capture datapath.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      shift   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            busy  = 1'b1;
            cap_d = {cap_q[WIDTH-2:0], serial_data_in};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = PUSH;
            end
         end
         PUSH: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky flags and FIFO bookkeeping; clear_flags beats a same-edge set.
   always_comb begin
      ovf_d    = ovf_q;
      missed_d = missed_q;
      if ((state_q == PUSH) && !wr_en) begin
         ovf_d = 1'b1;
      end
      if (frame_start && (state_q != IDLE)) begin
         missed_d = 1'b1;
      end
      if (clear_flags) begin
         ovf_d    = 1'b0;
         missed_d = 1'b0;
      end
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({wr_en, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Control and capture registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         nd_q     <= 1'b0;
         cap_q    <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         nd_q     <= new_data;
         cap_q    <= cap_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         missed_q <= missed_d;
      end
   end

   // FIFO storage; contents only matter while counted in level.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= cap_q;
      end
   end

endmodule

// File: tb/tb_digital_filter_readout.sv
// Directed bench for digital_filter_readout with a bit-serial filter model.
module tb_digital_filter_readout;

   localparam int W = 12;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          new_data;
   logic          serial_data_in;
   logic          shift;
   logic          busy;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [2:0]    level;
   logic          overflow;
   logic          missed;
   logic          clear_flags;

   int            errs   = 0;
   int            checks = 0;

   // filter serial register model
   logic [W-1:0]  sreg = '0;
   logic          load_req;
   logic [W-1:0]  load_val;
   int            shift_cnt = 0;

   digital_filter_readout #(.WIDTH(W), .DEPTH(D)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .new_data       (new_data),
      .serial_data_in (serial_data_in),
      .shift          (shift),
      .busy           (busy),
      .dout           (dout),
      .dout_valid     (dout_valid),
      .dout_ready     (dout_ready),
      .level          (level),
      .overflow       (overflow),
      .missed         (missed),
      .clear_flags    (clear_flags)
   );

   always #5 clk = ~clk;

   assign serial_data_in = sreg[W-1];

   // Filter side: load a word on request, shift it out MSB first on shift.
   always @(posedge clk) begin
      if (load_req) sreg <= load_val;
      else if (shift) sreg <= {sreg[W-2:0], 1'b0};
      if (shift) shift_cnt <= shift_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One frame; pre=1 means new_data is already high and the word loaded.
   // rdy/clr are applied only across the PUSH edge; chain raises new_data
   // so the next frame starts in the IDLE cycle right after PUSH.
   task automatic send_frame(input logic [W-1:0] val, input bit pre, input bit chain,
                             input logic [W-1:0] next_val, input bit rdy, input bit clr,
                             output logic dv13, output int nshift);
      int s0;
      if (!pre) begin
         new_data = 1'b1; load_val = val; load_req = 1'b1;
         tick();
      end
      new_data = 1'b0; load_req = 1'b0;
      s0 = shift_cnt;
      repeat (13) tick();
      dv13 = dout_valid;
      dout_ready = rdy; clear_flags = clr;
      if (chain) begin
         new_data = 1'b1; load_val = next_val; load_req = 1'b1;
      end
      tick();
      dout_ready = 1'b0; clear_flags = 1'b0;
      nshift = shift_cnt - s0;
   endtask

   task automatic pop_check(input string tag, input logic [W-1:0] exp);
      check(tag, dout, exp);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
   endtask

   initial begin
      logic dv;
      int   ns;
      int   s0;
      rst_n = 1'b0; new_data = 1'b1; dout_ready = 1'b0; clear_flags = 1'b0;
      load_req = 1'b0; load_val = '0;
      tick();
      check("rst_shift", shift, 0);
      check("rst_busy", busy, 0);
      check("rst_dv", dout_valid, 0);
      check("rst_level", level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_missed", missed, 0);
      // new_data already low at release: no frame start
      new_data = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("no_start_busy", busy, 0);

      // single frame A5C
      send_frame(12'hA5C, 0, 0, 12'h000, 0, 0, dv, ns);
      check("a5c_dv13", dv, 0);
      check("a5c_dv14", dout_valid, 1);
      check("a5c_shifts", ns, 12);
      check("a5c_dout", dout, 12'hA5C);
      check("a5c_level", level, 1);
      check("a5c_busy", busy, 0);
      pop_check("a5c_pop", 12'hA5C);
      check("a5c_empty", level, 0);
      // pop on empty is a no-op
      dout_ready = 1'b1; tick(); dout_ready = 1'b0;
      check("empty_pop_level", level, 0);

      // five back-to-back frames into a depth-4 FIFO
      send_frame(12'h001, 0, 1, 12'h7FF, 0, 0, dv, ns);
      send_frame(12'h7FF, 1, 1, 12'h800, 0, 0, dv, ns);
      send_frame(12'h800, 1, 1, 12'hFFF, 0, 0, dv, ns);
      send_frame(12'hFFF, 1, 1, 12'h123, 0, 0, dv, ns);
      send_frame(12'h123, 1, 0, 12'h000, 0, 0, dv, ns);
      check("five_level", level, 4);
      check("five_ovf", overflow, 1);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      check("ovf_cleared", overflow, 0);
      check("five_head", dout, 12'h001);

      // full FIFO with a pop on the PUSH edge
      send_frame(12'h456, 0, 0, 12'h000, 1, 0, dv, ns);
      check("fullpop_level", level, 4);
      check("fullpop_ovf", overflow, 0);
      pop_check("order0", 12'h7FF);
      pop_check("order1", 12'h800);
      pop_check("order2", 12'hFFF);
      pop_check("order3", 12'h456);
      check("order_empty", level, 0);

      // clear_flags on the edge that would set overflow
      send_frame(12'h111, 0, 0, 12'h000, 0, 0, dv, ns);
      send_frame(12'h222, 0, 0, 12'h000, 0, 0, dv, ns);
      send_frame(12'h333, 0, 0, 12'h000, 0, 0, dv, ns);
      send_frame(12'h444, 0, 0, 12'h000, 0, 0, dv, ns);
      send_frame(12'h555, 0, 0, 12'h000, 0, 1, dv, ns);
      check("clr_ovf_prio", overflow, 0);
      check("clr_ovf_level", level, 4);
      pop_check("clr_pop0", 12'h111);
      pop_check("clr_pop1", 12'h222);
      pop_check("clr_pop2", 12'h333);
      pop_check("clr_pop3", 12'h444);
      check("clr_empty", level, 0);

      // second frame start 5 cycles into a capture
      new_data = 1'b1; load_val = 12'h5A5; load_req = 1'b1; tick();
      new_data = 1'b0; load_req = 1'b0; s0 = shift_cnt;
      tick();
      repeat (5) tick();
      new_data = 1'b1; tick();
      new_data = 1'b0; tick();
      check("missed_set", missed, 1);
      check("missed_busy", busy, 1);
      repeat (6) tick();
      check("missed_shifts", shift_cnt - s0, 12);
      check("missed_busy_end", busy, 0);
      check("missed_level", level, 1);
      check("missed_dout", dout, 12'h5A5);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      check("missed_cleared", missed, 0);

      // clear_flags on the edge that would set missed
      new_data = 1'b1; load_val = 12'h0F0; load_req = 1'b1; tick();
      new_data = 1'b0; load_req = 1'b0;
      repeat (6) tick();
      new_data = 1'b1; tick();
      new_data = 1'b0; clear_flags = 1'b1; tick();
      clear_flags = 1'b0;
      check("clr_missed_prio", missed, 0);
      repeat (6) tick();
      check("second_level", level, 2);
      pop_check("missed_pop0", 12'h5A5);
      pop_check("missed_pop1", 12'h0F0);

      // reset in the middle of a capture
      new_data = 1'b1; load_val = 12'h777; load_req = 1'b1; tick();
      new_data = 1'b0; load_req = 1'b0;
      tick();
      repeat (6) tick();
      check("pre_rst_shift", shift, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_shift", shift, 0);
      check("rst_async_busy", busy, 0);
      @(negedge clk);
      check("rst_hold_shift", shift, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_level", level, 0);
      check("post_rst_dv", dout_valid, 0);
      send_frame(12'h3C3, 0, 0, 12'h000, 0, 0, dv, ns);
      check("3c3_shifts", ns, 12);
      check("3c3_level", level, 1);
      check("3c3_dout", dout, 12'h3C3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/digital_filter_readout.md
DIGITAL_FILTER_READOUT -- requirements
Module: digital_filter_readout

Interface
REQ-001 Parameter WIDTH, default 12, bit width of one filter output word.
REQ-002 Parameter DEPTH, default 4, FIFO depth in words; power of two, at least 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 new_data  input  1  filter result-ready flag; its falling edge marks a word loaded into the filter's serial register.
REQ-006 serial_data_in  input  1  filter serial output, MSB first; advances by one bit on each clk edge with shift=1.
REQ-007 shift  output  1  shift strobe to the filter.
REQ-008 busy  output  1  high while a serial capture is in progress.
REQ-009 dout  output  WIDTH  head-of-FIFO word, first-word-fall-through.
REQ-010 dout_valid  output  1  FIFO not empty.
REQ-011 dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready at a clk edge.
REQ-012 level  output  clog2(DEPTH)+1  number of words in the FIFO.
REQ-013 overflow  output  1  sticky; set when a completed word is dropped.
REQ-014 missed  output  1  sticky; set when a frame start arrives during a capture.
REQ-015 clear_flags  input  1  synchronous clear of overflow and missed.

Function
REQ-016 Edge detect: nd_q registers new_data; a frame start is nd_q=1 && new_data=0, evaluated on each edge.
REQ-017 FSM states: IDLE, SHIFT, PUSH.
REQ-018 IDLE -> SHIFT on a frame start; bit counter cleared to 0.
REQ-019 In SHIFT, shift=1 combinationally (shift = state==SHIFT).
REQ-020 In SHIFT, each edge sets cap <= {cap[WIDTH-2:0], serial_data_in} and increments the bit counter; the sample is the pre-shift bit.
REQ-021 SHIFT -> PUSH on the edge that captures bit WIDTH-1; exactly WIDTH shift-high cycles per frame.
REQ-022 PUSH lasts one cycle: the word is written to the FIFO if not full, or if full with a same-cycle pop; else dropped and overflow set; then -> IDLE.
REQ-023 A frame start in SHIFT or PUSH is ignored and sets missed; no restart of the capture.
REQ-024 A frame start in the IDLE cycle right after PUSH is accepted normally.
REQ-025 Latency: frame start edge to dout_valid (FIFO previously empty) = WIDTH+2 edges.
REQ-026 busy=1 in SHIFT and PUSH, else 0.
REQ-027 FIFO: circular buffer with read/write pointers mod DEPTH; pop on dout_valid && dout_ready; pop when empty is a no-op; full = level==DEPTH.
REQ-028 Simultaneous push and pop: level unchanged; when empty, no pop occurs and level becomes 1.
REQ-029 dout is valid only while dout_valid=1; its value when empty is don't-care.
REQ-030 clear_flags has priority over a same-cycle set; it does not affect the FIFO or the FSM.

Reset
REQ-031 rst_n low asynchronously forces IDLE, nd_q=0, cap=0, bit counter=0, pointers=0, level=0, shift=0, busy=0, dout_valid=0, overflow=0, missed=0.
REQ-032 Reset mid-capture abandons the partial word; no FIFO write occurs.
REQ-033 After reset release, a new_data level already low causes no frame start.

Verification
REQ-034 Bit-serial model presents 12'hA5C; pulse new_data, then hold dout_ready=0 -> exactly 12 shift-high cycles, dout=12'hA5C, dout_valid high WIDTH+2 edges after the falling edge, level=1.
REQ-035 Five frames (12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h123) with dout_ready=0 -> level=4, overflow=1, popping yields 001, 7FF, 800, FFF.
REQ-036 Second new_data falling edge 5 cycles into a capture -> missed=1; first word intact; shift count for that frame still 12.
REQ-037 FIFO full, dout_ready=1 held through a PUSH -> no overflow, level stays 4, output order preserved.
REQ-038 rst_n low at bit 6 of a capture, then one full frame of 12'h3C3 -> level=1, dout=12'h3C3, shift=0 during reset.
REQ-039 clear_flags asserted on the same edge that would set overflow -> overflow=0 afterwards; missed cleared in the same way.
